// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction/data requester ports and memory bus of the arbiter
interface mem_arbiter_if #(parameter int WORD = 16);
  logic i_req;
  logic [WORD-1:0] i_addr;
  logic i_ready;
  logic [WORD-1:0] i_rdata;
  logic d_req;
  logic d_we;
  logic [WORD-1:0] d_addr;
  logic [WORD-1:0] d_wdata;
  logic d_ready;
  logic [WORD-1:0] d_rdata;
  logic mem_read;
  logic mem_write;
  logic [WORD-1:0] mem_addr;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] mem_rdata;
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory between fetch and data ports
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int WORD = 16
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [3:0] LAST = 4'(LATENCY - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic owner, last_owner, we_q, grant_d, any_req, wr;
  logic [WORD-1:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
  // next state and round-robin winner (owner/last_owner: 1 = data port)
  always_comb begin
    any_req = bus.i_req || bus.d_req;
    grant_d = bus.d_req && (!bus.i_req || !last_owner);
    wr = owner && we_q;
    state_nx = state;
    if (state == IDLE) state_nx = any_req ? BUSY : IDLE;
    else if (state == BUSY) state_nx = cnt == LAST ? DONE : BUSY;
    else state_nx = IDLE;
  end
  // state register and access-length counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_nx;
      cnt <= state == BUSY ? cnt + 4'd1 : 4'd0;
    end
  end
  // grant latches and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= 1'b0;
      last_owner <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        owner <= grant_d;
        last_owner <= grant_d;
        addr_q <= grant_d ? bus.d_addr : bus.i_addr;
        if (grant_d) begin
          we_q <= bus.d_we;
          wdata_q <= bus.d_wdata;
        end
      end
      if (state == BUSY && cnt == LAST && !wr) begin
        if (owner) d_rdata_q <= bus.mem_rdata;
        else i_rdata_q <= bus.mem_rdata;
      end
    end
  end
  assign bus.mem_read = state == BUSY && !wr;
  assign bus.mem_write = state == BUSY && wr;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ready = state == DONE && !owner;
  assign bus.d_ready = state == DONE && owner;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LATENCY, default 4: memory access latency in cycles; legal range 1..15.
REQ-002 Parameter WORD, default 16: address and data width, equal to `NumBits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_req  input  1  instruction-fetch request; held high until i_ready.
REQ-006 i_addr  input  WORD  fetch address; sampled at grant.
REQ-007 i_ready  output  1  one-cycle pulse; fetch complete.
REQ-008 i_rdata  output  WORD  fetched word; valid while i_ready=1.
REQ-009 d_req  input  1  data-access request; held high until d_ready.
REQ-010 d_we  input  1  1 = write, 0 = read; sampled at grant.
REQ-011 d_addr  input  WORD  data address; sampled at grant.
REQ-012 d_wdata  input  WORD  write data; sampled at grant.
REQ-013 d_ready  output  1  one-cycle pulse; data access complete (read or write).
REQ-014 d_rdata  output  WORD  read word; valid while d_ready=1 after a read.
REQ-015 mem_read  output  1  memory read strobe.
REQ-016 mem_write  output  1  memory write strobe.
REQ-017 mem_addr  output  WORD  memory address.
REQ-018 mem_wdata  output  WORD  memory write data.
REQ-019 mem_rdata  input  WORD  memory read data; valid in the last strobe cycle.

Function
REQ-020 FSM states: IDLE, BUSY, DONE; owner register: I or D; last_owner register: I or D.
REQ-021 IDLE, only d_req=1: grant D at the next edge; go to BUSY; counter cleared to 0.
REQ-022 IDLE, only i_req=1: grant I at the next edge; go to BUSY; counter cleared to 0.
REQ-023 IDLE, both requests: grant the requester that is not last_owner (round robin).
REQ-024 IDLE, no request: stay in IDLE.
REQ-025 At grant: owner and last_owner set to the winner; the winner's address, d_we and d_wdata latched; D's we/wdata latched only when D wins.
REQ-026 BUSY: counter increments each cycle; after the cycle with counter=LATENCY-1, go to DONE.
REQ-027 BUSY: mem_addr, mem_wdata and the write flag come from the latches, so later input changes have no effect.
REQ-028 BUSY strobes: mem_read=1 unless owner=D with latched we=1; mem_write=1 only when owner=D with latched we=1; strobes held for exactly LATENCY cycles.
REQ-029 Last BUSY cycle of a read: mem_rdata captured into the owner's rdata register.
REQ-030 DONE: lasts one cycle; owner's ready=1 and the other ready=0; then go to IDLE.
REQ-031 IDLE and DONE: mem_read=mem_write=0; mem_addr and mem_wdata hold their last values.
REQ-032 Write completion: d_rdata keeps its previous value.
REQ-033 i_rdata and d_rdata hold their values until the next capture.
REQ-034 A requester still high in the IDLE cycle after its ready pulse is treated as a new request.
REQ-035 Per-access occupancy: 1 grant cycle (IDLE) + LATENCY + 1 (DONE); no pipelining of accesses.
REQ-036 Requests arriving in BUSY or DONE wait; no request is dropped.
REQ-037 Both ready outputs are never high in the same cycle; mem_read and mem_write are never high in the same cycle.

Reset
REQ-038 reset=1 at an edge: state=IDLE, counter=0, owner=I, last_owner=I.
REQ-039 reset=1 at an edge: all ready and strobe outputs 0; i_rdata, d_rdata, mem_addr and mem_wdata set to 0.
REQ-040 Reset during BUSY or DONE aborts the access: no ready pulse is issued and strobes drop at that edge.
REQ-041 Requests held high through reset are arbitrated normally from the first IDLE cycle after reset falls.

Verification
REQ-042 LATENCY=4; i_req, i_addr=0x0010; memory returns 0xBEEF -> mem_read high 4 cycles with mem_addr=0x0010; i_ready pulses once with i_rdata=0xBEEF; edge-to-ready = 6 cycles.
REQ-043 d_req, d_we=1, d_addr=0x0200, d_wdata=0x1234 -> mem_write high 4 cycles with 0x0200/0x1234; mem_read=0 throughout; d_ready pulses; d_rdata unchanged.
REQ-044 Both requests held high after reset -> grant order D, I, D, I; i_ready and d_ready alternate and never overlap.
REQ-045 i_addr changed to 0xFFFF in the second BUSY cycle -> mem_addr stays at the latched value; ready timing unchanged.
REQ-046 reset asserted in the third BUSY cycle of a read -> strobes 0 at that edge; no ready pulse; d_rdata=0; a fresh request then completes normally.
REQ-047 LATENCY=1 build; single data read -> mem_read high exactly 1 cycle; d_ready in the following cycle.
